// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES payload registers with valid/ready backpressure,
// per-stage flush, bubble collapsing and wrap-around performance counters.
module pipe_stage_chain #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int CNT_W  = 32
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   input  logic [STAGES-1:0]             flush,
   output logic [$clog2(STAGES+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]              accepted_count,
   output logic [CNT_W-1:0]              delivered_count,
   output logic [CNT_W-1:0]              flushed_count
);

   localparam int OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0] valid_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [STAGES:0]   rdy;
   logic              rdy_carry;
   logic [STAGES-1:0] live;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] leave;
   logic [WIDTH-1:0]  up_data [STAGES];
   logic [CNT_W-1:0]  kill_sum;
   logic [OCC_W-1:0]  occ_sum;

   // Ready ripples from the output end back toward stage 0; a flushed stage refuses input.
   always_comb begin
      rdy         = '0;
      rdy_carry   = out_ready;
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         rdy_carry = ~flush[i] & (~valid_q[i] | rdy_carry);
         rdy[i]    = rdy_carry;
      end
   end

   assign live = valid_q & ~flush;

   always_comb begin
      load  = '0;
      leave = '0;
      for (int i = 0; i < STAGES; i++) begin
         up_data[i] = in_data;
      end
      load[0] = in_valid & rdy[0];
      for (int i = 1; i < STAGES; i++) begin
         load[i]    = live[i-1] & rdy[i];
         up_data[i] = data_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
         leave[i] = live[i] & rdy[i+1];
      end
   end

   // Flush wins over everything and leaves the stale payload in place.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
               valid_q[i] <= 1'b0;
            end else if (load[i]) begin
               valid_q[i] <= 1'b1;
               data_q[i]  <= up_data[i];
            end else if (leave[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      kill_sum = '0;
      occ_sum  = '0;
      for (int i = 0; i < STAGES; i++) begin
         kill_sum = kill_sum + CNT_W'(valid_q[i] & flush[i]);
         occ_sum  = occ_sum + OCC_W'(valid_q[i]);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         accepted_count  <= '0;
         delivered_count <= '0;
         flushed_count   <= '0;
      end else begin
         accepted_count  <= accepted_count + CNT_W'(in_valid & in_ready);
         delivered_count <= delivered_count + CNT_W'(out_valid & out_ready);
         flushed_count   <= flushed_count + kill_sum;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = live[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: a scoreboard queue tracks items
// in flight, a vector table covers backpressure, hand sequences cover the rest.
module tb_pipe_stage_chain;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;
   localparam int CNT_W  = 4;
   localparam int OCC_W  = $clog2(STAGES+1);

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  out_data;
   logic [STAGES-1:0] flush = '0;
   logic [OCC_W-1:0]  occupancy;
   logic [CNT_W-1:0]  accepted_count;
   logic [CNT_W-1:0]  delivered_count;
   logic [CNT_W-1:0]  flushed_count;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q [$];

   typedef struct {
      logic              iv;
      logic [WIDTH-1:0]  d;
      logic              orr;
      logic [STAGES-1:0] f;
      logic              exp_in_ready;
      logic              exp_out_valid;
      int                exp_occ;
   } vec_t;

   vec_t bp_tbl [12];

   always #5 CLK = ~CLK;

   pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .flush           (flush),
      .occupancy       (occupancy),
      .accepted_count  (accepted_count),
      .delivered_count (delivered_count),
      .flushed_count   (flushed_count)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic iv, input logic [WIDTH-1:0] d, input logic orr,
                                 input logic [STAGES-1:0] f);
      in_valid  = iv;
      in_data   = d;
      out_ready = orr;
      flush     = f;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      apply_stimulus(1'b0, '0, 1'b0, '0);
      RST = 1'b1;
      next_cycle();
      RST = 1'b0;
      exp_q.delete();
   endtask

   task automatic idle_cycles(input int n, input logic orr);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0, '0, orr, '0);
         next_cycle();
      end
   endtask

   // Scoreboard: record accepted payloads, compare each delivered payload in order.
   always @(negedge CLK) begin
      if (!RST) begin
         if (in_valid && in_ready) exp_q.push_back(in_data);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_delivery: got 0x%0h, expected no item", out_data);
            end else begin
               check_output("scoreboard_data", out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bp_tbl[0]  = '{1'b1, 32'hA0, 1'b0, 4'b0000, 1'b1, 1'b0, 0};
      bp_tbl[1]  = '{1'b1, 32'hA1, 1'b0, 4'b0000, 1'b1, 1'b0, 1};
      bp_tbl[2]  = '{1'b1, 32'hA2, 1'b0, 4'b0000, 1'b1, 1'b0, 2};
      bp_tbl[3]  = '{1'b1, 32'hA3, 1'b0, 4'b0000, 1'b1, 1'b0, 3};
      bp_tbl[4]  = '{1'b1, 32'hA4, 1'b0, 4'b0000, 1'b0, 1'b1, 4};
      bp_tbl[5]  = '{1'b1, 32'hA4, 1'b0, 4'b0000, 1'b0, 1'b1, 4};
      bp_tbl[6]  = '{1'b1, 32'hA4, 1'b1, 4'b0000, 1'b1, 1'b1, 4};
      bp_tbl[7]  = '{1'b0, 32'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 4};
      bp_tbl[8]  = '{1'b0, 32'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 3};
      bp_tbl[9]  = '{1'b0, 32'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 2};
      bp_tbl[10] = '{1'b0, 32'h00, 1'b1, 4'b0000, 1'b1, 1'b1, 1};
      bp_tbl[11] = '{1'b0, 32'h00, 1'b1, 4'b0000, 1'b1, 1'b0, 0};

      next_cycle();
      do_reset();
      @(negedge CLK);
      check_output("reset_out_valid", out_valid, 1'b0);
      check_output("reset_occupancy", occupancy, 0);
      check_output("reset_in_ready", in_ready, 1'b1);
      next_cycle();

      // Reset mid-stream: three items in flight are discarded immediately.
      for (int c = 0; c < 3; c++) begin
         apply_stimulus(1'b1, 32'h31 + c, 1'b0, '0);
         next_cycle();
      end
      apply_stimulus(1'b0, '0, 1'b0, '0);
      #2;
      check_output("pre_reset_occupancy", occupancy, 3);
      check_output("pre_reset_accepted", accepted_count, 3);
      RST = 1'b1;
      #1;
      check_output("async_rst_out_valid", out_valid, 1'b0);
      check_output("async_rst_out_data", out_data, 0);
      check_output("async_rst_occupancy", occupancy, 0);
      check_output("async_rst_accepted", accepted_count, 0);
      check_output("async_rst_in_ready", in_ready, 1'b1);
      #2;
      RST = 1'b0;
      exp_q.delete();
      next_cycle();
      for (int c = 0; c < 6; c++) begin
         apply_stimulus(c == 0, 32'h99, 1'b1, '0);
         @(negedge CLK);
         check_output($sformatf("post_reset_latency_c%0d", c), out_valid, c == 4);
         next_cycle();
      end
      check_output("post_reset_queue_empty", exp_q.size(), 0);

      // Streaming: eight back-to-back items at one per cycle.
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         apply_stimulus(c < 8, 32'h10 + c, 1'b1, '0);
         @(negedge CLK);
         check_output($sformatf("stream_out_valid_c%0d", c), out_valid, (c >= 4) && (c < 12));
         check_output($sformatf("stream_occ_c%0d", c), occupancy,
                      ((c < 8) ? c : 8) - ((c > 4) ? (c - 4) : 0));
         if (c < 8) check_output($sformatf("stream_in_ready_c%0d", c), in_ready, 1'b1);
         next_cycle();
      end
      check_output("stream_accepted", accepted_count, 8);
      check_output("stream_delivered", delivered_count, 8);
      check_output("stream_queue_empty", exp_q.size(), 0);

      // Backpressure from the vector table.
      do_reset();
      for (int r = 0; r < 12; r++) begin
         apply_stimulus(bp_tbl[r].iv, bp_tbl[r].d, bp_tbl[r].orr, bp_tbl[r].f);
         @(negedge CLK);
         check_output($sformatf("bp_in_ready_r%0d", r), in_ready, bp_tbl[r].exp_in_ready);
         check_output($sformatf("bp_out_valid_r%0d", r), out_valid, bp_tbl[r].exp_out_valid);
         check_output($sformatf("bp_occ_r%0d", r), occupancy, bp_tbl[r].exp_occ);
         next_cycle();
      end
      check_output("bp_accepted", accepted_count, 5);
      check_output("bp_delivered", delivered_count, 5);
      check_output("bp_queue_empty", exp_q.size(), 0);

      // Flush the two middle stages of a full, stalled chain.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         apply_stimulus(1'b1, 32'h1 + c, 1'b0, '0);
         next_cycle();
      end
      apply_stimulus(1'b0, '0, 1'b0, 4'b0110);
      @(negedge CLK);
      check_output("fmid_occ_during", occupancy, 4);
      check_output("fmid_out_valid", out_valid, 1'b1);
      check_output("fmid_in_ready", in_ready, 1'b0);
      next_cycle();
      exp_q.delete(2);
      exp_q.delete(1);
      apply_stimulus(1'b0, '0, 1'b0, '0);
      @(negedge CLK);
      check_output("fmid_occ_after", occupancy, 2);
      check_output("fmid_flushed", flushed_count, 2);
      next_cycle();
      idle_cycles(6, 1'b1);
      check_output("fmid_delivered", delivered_count, 2);
      check_output("fmid_queue_empty", exp_q.size(), 0);

      // Flush the head while downstream is ready: nothing is delivered.
      do_reset();
      apply_stimulus(1'b1, 32'h55, 1'b0, '0);
      next_cycle();
      idle_cycles(3, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, '0);
      @(negedge CLK);
      check_output("fhead_before", out_valid, 1'b1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b1, 4'b1000);
      @(negedge CLK);
      check_output("fhead_out_valid", out_valid, 1'b0);
      check_output("fhead_occ_during", occupancy, 1);
      next_cycle();
      exp_q.delete(0);
      apply_stimulus(1'b0, '0, 1'b1, '0);
      @(negedge CLK);
      check_output("fhead_out_valid_after", out_valid, 1'b0);
      check_output("fhead_delivered", delivered_count, 0);
      check_output("fhead_flushed", flushed_count, 1);
      check_output("fhead_occ_after", occupancy, 0);
      next_cycle();

      // Counter wrap: sixteen deliveries bring a 4-bit counter back to zero.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         apply_stimulus(c < 16, 32'hC0 + c, 1'b1, '0);
         next_cycle();
      end
      check_output("wrap_delivered", delivered_count, 0);
      check_output("wrap_accepted", accepted_count, 0);
      check_output("wrap_queue_empty", exp_q.size(), 0);

      // Bubble collapse: new input packs up behind a stalled head item.
      do_reset();
      apply_stimulus(1'b1, 32'h77, 1'b0, '0);
      next_cycle();
      idle_cycles(3, 1'b0);
      apply_stimulus(1'b1, 32'h78, 1'b0, '0);
      @(negedge CLK);
      check_output("collapse_in_ready", in_ready, 1'b1);
      check_output("collapse_out_valid", out_valid, 1'b1);
      next_cycle();
      idle_cycles(3, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, '0);
      @(negedge CLK);
      check_output("collapse_occ", occupancy, 2);
      check_output("collapse_first", out_valid, 1'b1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b1, '0);
      @(negedge CLK);
      check_output("collapse_second_adjacent", out_valid, 1'b1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b1, '0);
      @(negedge CLK);
      check_output("collapse_drained", out_valid, 1'b0);
      check_output("collapse_delivered", delivered_count, 2);
      check_output("collapse_queue_empty", exp_q.size(), 0);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
